// File: rtl/adc_serial_rx_if.sv
// ADC serial readout bundle: the conversion/clock/data lines coming from the
// converter side and the parallel sample results going to the consumer.
interface adc_serial_rx_if #(
    parameter int dataWidth = 18
);
    logic                 cnv;
    logic                 adcClk;
    logic                 sdo;
    logic [dataWidth-1:0] dataOut;
    logic                 dataValid;
    logic                 frameError;
    logic [15:0]          errorCount;

    // Converter/generator side: drives the frame and observes the results
    modport master (
        output cnv, adcClk, sdo,
        input  dataOut, dataValid, frameError, errorCount
    );

    // Receiver side: consumes the serial stream and produces parallel words
    modport slave (
        input  cnv, adcClk, sdo,
        output dataOut, dataValid, frameError, errorCount
    );
endinterface

// File: rtl/adc_serial_rx.sv
// Deserialises the ADC serial output into parallel words. A rising edge of
// cnv opens a frame, detected adcClk edges (rising only, or both in DDR mode)
// shift in the delay-compensated sdo MSB first, and a finished word is
// presented with a one-cycle valid strobe. A new cnv in the middle of a frame
// discards the partial word and is counted as a truncated frame.
module adc_serial_rx #(
    parameter int dataWidth = 18,
    parameter bit ddr       = 1'b1,
    parameter int sdoDelay  = 2
) (
    input logic            clk,
    input logic            resetN,
    adc_serial_rx_if.slave bus
);

    localparam int countWidth = $clog2(dataWidth + 1);
    localparam logic [countWidth-1:0] lastCount = countWidth'(dataWidth - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } rxState_e;

    rxState_e              state;
    logic                  cnvD;
    logic                  adcClkD;
    logic                  cnvRise;
    logic                  sckRise;
    logic                  sckFall;
    logic                  sckEdge;
    logic                  sdoDly;
    logic [dataWidth-1:0]  shiftReg;
    logic [countWidth-1:0] bitCount;

    // Previous-cycle copies of cnv and adcClk for edge detection
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnvD    <= 1'b0;
            adcClkD <= 1'b0;
        end else begin
            cnvD    <= bus.cnv;
            adcClkD <= bus.adcClk;
        end
    end

    assign cnvRise = bus.cnv & ~cnvD;
    assign sckRise = bus.adcClk & ~adcClkD;
    assign sckFall = ~bus.adcClk & adcClkD;
    assign sckEdge = sckRise | (ddr & sckFall);

    generate
        if (sdoDelay == 0) begin : gDirect
            assign sdoDly = bus.sdo;
        end else begin : gDelay
            logic [sdoDelay-1:0] sdoPipe;

            // Delay line so a clock edge at cycle t samples sdo from t - sdoDelay
            always_ff @(posedge clk or negedge resetN) begin
                if (!resetN) begin
                    sdoPipe <= '0;
                end else begin
                    sdoPipe[0] <= bus.sdo;
                    for (int i = 1; i < sdoDelay; i++) begin
                        sdoPipe[i] <= sdoPipe[i-1];
                    end
                end
            end

            assign sdoDly = sdoPipe[sdoDelay-1];
        end
    endgenerate

    // Frame FSM with registered word, strobes and truncated-frame counter
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state          <= IDLE;
            shiftReg       <= '0;
            bitCount       <= '0;
            bus.dataOut    <= '0;
            bus.dataValid  <= 1'b0;
            bus.frameError <= 1'b0;
            bus.errorCount <= '0;
        end else begin
            bus.dataValid  <= 1'b0;
            bus.frameError <= 1'b0;
            case (state)
                IDLE: begin
                    if (cnvRise) begin
                        state    <= SHIFT;
                        bitCount <= '0;
                        shiftReg <= '0;
                    end
                end
                SHIFT: begin
                    if (cnvRise) begin
                        if (bitCount != '0) begin
                            bus.frameError <= 1'b1;
                            if (bus.errorCount != 16'hFFFF) begin
                                bus.errorCount <= bus.errorCount + 16'd1;
                            end
                        end
                        bitCount <= '0;
                        shiftReg <= '0;
                    end else if (sckEdge) begin
                        shiftReg <= {shiftReg[dataWidth-2:0], sdoDly};
                        bitCount <= bitCount + 1'b1;
                        if (bitCount == lastCount) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    bus.dataOut   <= shiftReg;
                    bus.dataValid <= 1'b1;
                    if (cnvRise) begin
                        state    <= SHIFT;
                        bitCount <= '0;
                        shiftReg <= '0;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_serial_rx.sv
// Directed bench for adc_serial_rx. Three receivers share clock and reset:
// dutA (18-bit DDR, no delay), dutB (18-bit DDR, delay 3) on the same cnv and
// adcClk, and dutC (9-bit SDR, delay 2) on its own frame signals.
module tb_adc_serial_rx;

    logic clk;
    logic resetN;
    logic cnv;
    logic adcClk;
    logic sdoA;
    logic sdoB;
    logic cnvC;
    logic sckC;
    logic sdoC;

    int vectors;
    int miscompares;

    int nValidA;
    int validAtA;
    int nErrA;
    int errAtA;
    int nValidB;
    int nHoldA;

    adc_serial_rx_if #(.dataWidth(18)) ifA ();
    adc_serial_rx_if #(.dataWidth(18)) ifB ();
    adc_serial_rx_if #(.dataWidth(9))  ifC ();

    assign ifA.cnv    = cnv;
    assign ifA.adcClk = adcClk;
    assign ifA.sdo    = sdoA;
    assign ifB.cnv    = cnv;
    assign ifB.adcClk = adcClk;
    assign ifB.sdo    = sdoB;
    assign ifC.cnv    = cnvC;
    assign ifC.adcClk = sckC;
    assign ifC.sdo    = sdoC;

    adc_serial_rx #(.dataWidth(18), .ddr(1'b1), .sdoDelay(0)) dutA (
        .clk(clk), .resetN(resetN), .bus(ifA.slave)
    );
    adc_serial_rx #(.dataWidth(18), .ddr(1'b1), .sdoDelay(3)) dutB (
        .clk(clk), .resetN(resetN), .bus(ifB.slave)
    );
    adc_serial_rx #(.dataWidth(9), .ddr(1'b0), .sdoDelay(2)) dutC (
        .clk(clk), .resetN(resetN), .bus(ifC.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bit carried on sdo at cycle c: edge k sits at firstEdge + 2k and its bit
    // is held for the two cycles starting there, MSB of pat[nEdges-1:0] first.
    function automatic logic patBit(input logic [31:0] pat, input int nEdges,
                                    input int firstEdge, input int c);
        int k;
        if (c < firstEdge || c >= firstEdge + 2 * nEdges) return 1'b0;
        k = (c - firstEdge) / 2;
        return pat[nEdges-1-k];
    endfunction

    // SDR stimulus: rising edge k at 4 + 4k; its bit is valid the two cycles
    // before it, and the inverted bit is shown around the falling edge.
    function automatic logic sdrBit(input logic [8:0] pat, input int c);
        int k;
        if (c < 2) return 1'b0;
        k = (c - 2) / 4;
        if (k > 8) return 1'b0;
        if (((c - 2) % 4) < 2) return pat[8-k];
        return ~pat[8-k];
    endfunction

    // Drives one frame on the shared A/B signals; sdoB leads sdoA by bShift.
    task automatic runFrame(input logic [31:0] pat, input int nEdges, input int firstEdge,
                            input int bShift, input bit withCnv);
        int total;
        logic [17:0] prevA;
        total    = firstEdge + 2 * nEdges + 4;
        nValidA  = 0;
        validAtA = -1;
        nErrA    = 0;
        errAtA   = -1;
        nValidB  = 0;
        nHoldA   = 0;
        prevA    = ifA.dataOut;
        for (int c = 0; c < total; c++) begin
            cnv = withCnv && (c < 2);
            if (c >= firstEdge && c < firstEdge + 2 * nEdges && ((c - firstEdge) % 2) == 0)
                adcClk = ~adcClk;
            sdoA = patBit(pat, nEdges, firstEdge, c);
            sdoB = patBit(pat, nEdges, firstEdge, c + bShift);
            @(posedge clk);
            #1;
            if (ifA.dataValid) begin
                nValidA++;
                validAtA = c;
            end
            if (ifA.frameError) begin
                nErrA++;
                errAtA = c;
            end
            if (ifB.dataValid) nValidB++;
            if (!ifA.dataValid && ifA.dataOut !== prevA) nHoldA++;
            prevA = ifA.dataOut;
        end
        cnv  = 1'b0;
        sdoA = 1'b0;
        sdoB = 1'b0;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if (ifA.dataOut !== 18'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_dataOut: got %h expected %h", ifA.dataOut, 18'h0);
        end
        vectors++;
        if (ifA.dataValid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_dataValid: got %b expected 0", ifA.dataValid);
        end
        vectors++;
        if (ifA.frameError !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_frameError: got %b expected 0", ifA.frameError);
        end
        vectors++;
        if (ifA.errorCount !== 16'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_errorCount: got %h expected 0000", ifA.errorCount);
        end
        vectors++;
        if (ifC.dataOut !== 9'h0) begin
            miscompares++;
            $display("[TB] FAIL reset_sdr_dataOut: got %h expected 000", ifC.dataOut);
        end
        resetN = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (ifA.dataValid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL idle_after_reset_dataValid: got %b expected 0", ifA.dataValid);
        end
    endtask

    task automatic test_nominal_ddr();
        runFrame(32'h2A5A5, 18, 4, 3, 1'b1);
        vectors++;
        if (ifA.dataOut !== 18'h2A5A5) begin
            miscompares++;
            $display("[TB] FAIL nominal_dataOut: got %h expected %h", ifA.dataOut, 18'h2A5A5);
        end
        vectors++;
        if (nValidA != 1) begin
            miscompares++;
            $display("[TB] FAIL nominal_valid_pulses: got %0d expected 1", nValidA);
        end
        vectors++;
        if (validAtA != 39) begin
            miscompares++;
            $display("[TB] FAIL nominal_valid_cycle: got %0d expected 39", validAtA);
        end
        vectors++;
        if (nErrA != 0) begin
            miscompares++;
            $display("[TB] FAIL nominal_frameError: got %0d pulses expected 0", nErrA);
        end
        vectors++;
        if (nHoldA != 0) begin
            miscompares++;
            $display("[TB] FAIL nominal_hold: got %0d changes without valid expected 0", nHoldA);
        end
        vectors++;
        if (ifB.dataOut !== 18'h2A5A5) begin
            miscompares++;
            $display("[TB] FAIL delay3_dataOut: got %h expected %h", ifB.dataOut, 18'h2A5A5);
        end
    endtask

    task automatic test_delay_comp();
        // Unaligned stream: delay-3 receiver sees each bit two edges late
        runFrame(32'h2A5A5, 18, 4, 0, 1'b1);
        vectors++;
        if (ifB.dataOut !== 18'h0A969) begin
            miscompares++;
            $display("[TB] FAIL delay3_unshifted_dataOut: got %h expected %h", ifB.dataOut, 18'h0A969);
        end
        vectors++;
        if (nValidB != 1) begin
            miscompares++;
            $display("[TB] FAIL delay3_valid_pulses: got %0d expected 1", nValidB);
        end
        vectors++;
        if (ifA.dataOut !== 18'h2A5A5) begin
            miscompares++;
            $display("[TB] FAIL nodelay_repeat_dataOut: got %h expected %h", ifA.dataOut, 18'h2A5A5);
        end
    endtask

    task automatic test_sdr();
        int nValidC;
        int validAtC;
        int nErrC;
        nValidC  = 0;
        validAtC = -1;
        nErrC    = 0;
        for (int c = 0; c < 42; c++) begin
            cnvC = (c < 2);
            sckC = (c >= 4 && c < 40 && ((c - 4) % 4) < 2);
            sdoC = sdrBit(9'h1B3, c);
            @(posedge clk);
            #1;
            if (ifC.dataValid) begin
                nValidC++;
                validAtC = c;
            end
            if (ifC.frameError) nErrC++;
        end
        cnvC = 1'b0;
        sckC = 1'b0;
        sdoC = 1'b0;
        vectors++;
        if (ifC.dataOut !== 9'h1B3) begin
            miscompares++;
            $display("[TB] FAIL sdr_dataOut: got %h expected %h", ifC.dataOut, 9'h1B3);
        end
        vectors++;
        if (nValidC != 1) begin
            miscompares++;
            $display("[TB] FAIL sdr_valid_pulses: got %0d expected 1", nValidC);
        end
        vectors++;
        if (validAtC != 37) begin
            miscompares++;
            $display("[TB] FAIL sdr_valid_cycle: got %0d expected 37", validAtC);
        end
        vectors++;
        if (nErrC != 0) begin
            miscompares++;
            $display("[TB] FAIL sdr_frameError: got %0d pulses expected 0", nErrC);
        end
    endtask

    task automatic test_truncated();
        runFrame(32'h155, 10, 4, 0, 1'b1);
        vectors++;
        if (nValidA != 0) begin
            miscompares++;
            $display("[TB] FAIL trunc_partial_valid: got %0d pulses expected 0", nValidA);
        end
        vectors++;
        if (ifA.dataOut !== 18'h2A5A5) begin
            miscompares++;
            $display("[TB] FAIL trunc_dataOut_held: got %h expected %h", ifA.dataOut, 18'h2A5A5);
        end
        runFrame(32'h3FFFF, 18, 4, 0, 1'b1);
        vectors++;
        if (nErrA != 1) begin
            miscompares++;
            $display("[TB] FAIL trunc_frameError_pulses: got %0d expected 1", nErrA);
        end
        vectors++;
        if (errAtA != 0) begin
            miscompares++;
            $display("[TB] FAIL trunc_frameError_cycle: got %0d expected 0", errAtA);
        end
        vectors++;
        if (ifA.errorCount !== 16'd1) begin
            miscompares++;
            $display("[TB] FAIL trunc_errorCount: got %0d expected 1", ifA.errorCount);
        end
        vectors++;
        if (ifA.dataOut !== 18'h3FFFF) begin
            miscompares++;
            $display("[TB] FAIL trunc_next_dataOut: got %h expected %h", ifA.dataOut, 18'h3FFFF);
        end
        vectors++;
        if (nValidA != 1) begin
            miscompares++;
            $display("[TB] FAIL trunc_next_valid_pulses: got %0d expected 1", nValidA);
        end
    endtask

    task automatic test_collision();
        // Leave a 5-bit partial frame, then restart with an edge on the cnv cycle
        runFrame(32'h15, 5, 4, 0, 1'b1);
        runFrame(32'h6B3C1, 19, 0, 0, 1'b1);
        vectors++;
        if (nErrA != 1) begin
            miscompares++;
            $display("[TB] FAIL collide_frameError_pulses: got %0d expected 1", nErrA);
        end
        vectors++;
        if (ifA.errorCount !== 16'd2) begin
            miscompares++;
            $display("[TB] FAIL collide_errorCount: got %0d expected 2", ifA.errorCount);
        end
        vectors++;
        if (ifA.dataOut !== 18'h2B3C1) begin
            miscompares++;
            $display("[TB] FAIL collide_dataOut: got %h expected %h", ifA.dataOut, 18'h2B3C1);
        end
        vectors++;
        if (nValidA != 1) begin
            miscompares++;
            $display("[TB] FAIL collide_valid_pulses: got %0d expected 1", nValidA);
        end
        vectors++;
        if (validAtA != 37) begin
            miscompares++;
            $display("[TB] FAIL collide_valid_cycle: got %0d expected 37", validAtA);
        end
    endtask

    task automatic test_extra_edges();
        runFrame(32'h1C0F3A, 22, 4, 0, 1'b1);
        vectors++;
        if (ifA.dataOut !== 18'h1C0F3) begin
            miscompares++;
            $display("[TB] FAIL extra_dataOut: got %h expected %h", ifA.dataOut, 18'h1C0F3);
        end
        vectors++;
        if (nValidA != 1) begin
            miscompares++;
            $display("[TB] FAIL extra_valid_pulses: got %0d expected 1", nValidA);
        end
        vectors++;
        if (validAtA != 39) begin
            miscompares++;
            $display("[TB] FAIL extra_valid_cycle: got %0d expected 39", validAtA);
        end
        vectors++;
        if (nErrA != 0) begin
            miscompares++;
            $display("[TB] FAIL extra_frameError: got %0d pulses expected 0", nErrA);
        end
        vectors++;
        if (nHoldA != 0) begin
            miscompares++;
            $display("[TB] FAIL extra_hold: got %0d changes without valid expected 0", nHoldA);
        end
    endtask

    task automatic test_reset_midframe();
        runFrame(32'h55, 7, 4, 0, 1'b1);
        #2;
        resetN = 1'b0;
        #1;
        vectors++;
        if (ifA.dataOut !== 18'h0) begin
            miscompares++;
            $display("[TB] FAIL midreset_dataOut: got %h expected %h", ifA.dataOut, 18'h0);
        end
        vectors++;
        if (ifA.errorCount !== 16'h0) begin
            miscompares++;
            $display("[TB] FAIL midreset_errorCount: got %0d expected 0", ifA.errorCount);
        end
        vectors++;
        if (ifA.dataValid !== 1'b0 || ifA.frameError !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_strobes: got valid %b error %b expected 0 0",
                     ifA.dataValid, ifA.frameError);
        end
        vectors++;
        if (ifC.dataOut !== 9'h0) begin
            miscompares++;
            $display("[TB] FAIL midreset_sdr_dataOut: got %h expected 000", ifC.dataOut);
        end
        repeat (3) @(posedge clk);
        #1;
        resetN = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        runFrame(32'h3FFFF, 18, 4, 0, 1'b0);
        vectors++;
        if (nValidA != 0) begin
            miscompares++;
            $display("[TB] FAIL nocnv_valid_pulses: got %0d expected 0", nValidA);
        end
        vectors++;
        if (ifA.dataOut !== 18'h0) begin
            miscompares++;
            $display("[TB] FAIL nocnv_dataOut: got %h expected %h", ifA.dataOut, 18'h0);
        end
        runFrame(32'h12345, 18, 4, 0, 1'b1);
        vectors++;
        if (ifA.dataOut !== 18'h12345) begin
            miscompares++;
            $display("[TB] FAIL postreset_dataOut: got %h expected %h", ifA.dataOut, 18'h12345);
        end
        vectors++;
        if (nValidA != 1) begin
            miscompares++;
            $display("[TB] FAIL postreset_valid_pulses: got %0d expected 1", nValidA);
        end
        vectors++;
        if (ifA.errorCount !== 16'h0) begin
            miscompares++;
            $display("[TB] FAIL postreset_errorCount: got %0d expected 0", ifA.errorCount);
        end
    endtask

    // Safety net so a stuck run still ends with a visible failure
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        resetN      = 1'b0;
        cnv         = 1'b0;
        adcClk      = 1'b0;
        sdoA        = 1'b0;
        sdoB        = 1'b0;
        cnvC        = 1'b0;
        sckC        = 1'b0;
        sdoC        = 1'b0;
        $display("[TB] adc_serial_rx directed bench starting");
        test_reset();
        test_nominal_ddr();
        test_delay_comp();
        test_sdr();
        test_truncated();
        test_collision();
        test_extra_edges();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
